mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 60 ++++++
 rtl/mem_stage_load_extract.sv | 41 ++++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB payloads, forwarding bundle,
// hazard controls and the MEM-stage load FSM state type.
package mem_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2
    } rf_wr_src_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } mem_width_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] next_pc;
        logic            rf_wr_en;
        rf_wr_src_e      rf_wr_src;
        logic            mem_read;
        logic            mem_sign;
        mem_width_e      mem_width;
    } exec_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } reg_meta_t;

    typedef struct packed {
        logic stall;
        logic squash;
    } stage_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            rf_wr_en;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            mem_read;
    } data_fwd_t;

    typedef struct packed {
        logic [XLEN-1:0] rd_data;
        logic            rf_wr_en;
    } mem_state_t;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_WAIT  = 2'd1,
        MEM_HOLD  = 2'd2,
        MEM_DRAIN = 2'd3
    } mem_fsm_e;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Selects the addressed byte/half/word of an aligned read word and
// sign- or zero-extends it to the register width.
module load_extract
    import mem_stage_pkg::*;
(
    input  mem_width_e      width,
    input  logic            sign,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to access width
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        value  = {XLEN{1'b0}};
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (width)
            WIDTH_BYTE: value = {{24{sign & byte_s[7]}}, byte_s};
            WIDTH_HALF: value = {{16{sign & half_s[15]}}, half_s};
            WIDTH_WORD: value = word;
            default:    value = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: result select, load response FSM with hold buffer for
// responses that arrive while the pipeline is externally stalled, MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  exec_state_t     exec_state_i,
    input  reg_meta_t       reg_meta_i,
    input  stage_ctrl_t     stage_ctrl_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            stall_req_o,
    output data_fwd_t       data_fwd_o,
    output logic            valid_o,
    output mem_state_t      mem_state_o,
    output reg_meta_t       reg_meta_o
);

    mem_fsm_e        state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            valid_q, valid_d;
    mem_state_t      mem_state_q, mem_state_d;
    reg_meta_t       reg_meta_q, reg_meta_d;

    logic            live_load_s;
    logic            stall_req_s;
    logic [XLEN-1:0] load_word_s;
    logic [XLEN-1:0] load_value_s;
    logic [XLEN-1:0] rd_data_s;

    assign live_load_s = valid_i & exec_state_i.mem_read & ~stage_ctrl_i.squash;

    // A load completing out of HOLD uses the buffered word, not the bus
    always_comb begin
        if (state_q == MEM_HOLD) begin
            load_word_s = hold_q;
        end else begin
            load_word_s = mem_rdata_i;
        end
    end

    load_extract u_load_extract (
        .width  (exec_state_i.mem_width),
        .sign   (exec_state_i.mem_sign),
        .offset (exec_state_i.alu_out[1:0]),
        .word   (load_word_s),
        .value  (load_value_s)
    );

    // Writeback value selection
    always_comb begin
        case (exec_state_i.rf_wr_src)
            SRC_ALU: rd_data_s = exec_state_i.alu_out;
            SRC_MEM: rd_data_s = load_value_s;
            SRC_PC4: rd_data_s = exec_state_i.next_pc;
            default: rd_data_s = exec_state_i.alu_out;
        endcase
    end

    // Load FSM next state, hold-buffer capture and stall request
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stall_req_s = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (live_load_s && !mem_rvalid_i) begin
                    state_d     = MEM_WAIT;
                    stall_req_s = 1'b1;
                end else if (live_load_s && stage_ctrl_i.stall) begin
                    state_d = MEM_HOLD;
                    hold_d  = mem_rdata_i;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (stage_ctrl_i.squash) begin
                    if (mem_rvalid_i) begin
                        state_d = MEM_IDLE;
                    end else begin
                        state_d     = MEM_DRAIN;
                        stall_req_s = 1'b1;
                    end
                end else if (mem_rvalid_i) begin
                    if (stage_ctrl_i.stall) begin
                        state_d = MEM_HOLD;
                        hold_d  = mem_rdata_i;
                    end else begin
                        state_d = MEM_IDLE;
                    end
                end else begin
                    stall_req_s = 1'b1;
                end
            end
            MEM_HOLD: begin
                if (stage_ctrl_i.squash || !stage_ctrl_i.stall) begin
                    state_d = MEM_IDLE;
                end else begin
                    state_d = MEM_HOLD;
                end
            end
            MEM_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = MEM_IDLE;
                end else begin
                    stall_req_s = 1'b1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign stall_req_o = stall_req_s & ~rst_i;

    // MEM/WB register: bubble while waiting or draining, hold under external stall
    always_comb begin
        valid_d     = valid_q;
        mem_state_d = mem_state_q;
        reg_meta_d  = reg_meta_q;
        if (stall_req_s || (state_q == MEM_DRAIN)) begin
            valid_d = 1'b0;
        end else if (stage_ctrl_i.stall) begin
            valid_d = valid_q;
        end else begin
            valid_d              = valid_i & ~stage_ctrl_i.squash;
            mem_state_d.rd_data  = rd_data_s;
            mem_state_d.rf_wr_en = exec_state_i.rf_wr_en;
            reg_meta_d           = reg_meta_i;
        end
    end

    // State and pipeline register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= MEM_IDLE;
            hold_q      <= {XLEN{1'b0}};
            valid_q     <= 1'b0;
            mem_state_q <= '0;
            reg_meta_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            valid_q     <= valid_d;
            mem_state_q <= mem_state_d;
            reg_meta_q  <= reg_meta_d;
        end
    end

    // Forward the stage result to EX; never flagged as a pending load
    always_comb begin
        data_fwd_o          = '0;
        data_fwd_o.valid    = valid_i & ~stage_ctrl_i.squash & ~stall_req_o;
        data_fwd_o.rf_wr_en = exec_state_i.rf_wr_en;
        data_fwd_o.rd       = reg_meta_i.rd;
        data_fwd_o.rd_data  = rd_data_s;
        data_fwd_o.mem_read = 1'b0;
    end

    assign valid_o     = valid_q;
    assign mem_state_o = mem_state_q;
    assign reg_meta_o  = reg_meta_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle
// sequences, and randomized transactions against a transaction-level model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    exec_state_t ex;
    reg_meta_t   meta;
    stage_ctrl_t ctrl;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall_req;
    data_fwd_t   fwd;
    logic        valid_o;
    mem_state_t  mem_state;
    reg_meta_t   meta_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .exec_state_i (ex),
        .reg_meta_i   (meta),
        .stage_ctrl_i (ctrl),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata),
        .stall_req_o  (stall_req),
        .data_fwd_o   (fwd),
        .valid_o      (valid_o),
        .mem_state_o  (mem_state),
        .reg_meta_o   (meta_o)
    );

    typedef struct {
        rf_wr_src_e  src;
        mem_width_e  width;
        logic        sign;
        logic [31:0] alu;
        logic [31:0] npc;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input rf_wr_src_e src, input mem_width_e w,
                          input logic s, input logic [31:0] alu, input logic [31:0] npc,
                          input logic [4:0] rd);
        valid          = v;
        ex.alu_out     = alu;
        ex.next_pc     = npc;
        ex.rf_wr_en    = 1'b1;
        ex.rf_wr_src   = src;
        ex.mem_read    = (src == SRC_MEM);
        ex.mem_sign    = s;
        ex.mem_width   = w;
        meta.rd        = rd;
        meta.rs1       = rd + 5'd1;
        meta.rs2       = rd + 5'd2;
    endtask

    // Architectural result of an instruction, from the load rules in plain arithmetic
    function automatic logic [31:0] ref_value(input rf_wr_src_e src, input mem_width_e w,
                                              input logic s, input logic [31:0] alu,
                                              input logic [31:0] npc, input logic [31:0] word);
        logic [31:0] off;
        logic [31:0] v;
        off = alu % 32'd4;
        if (src == SRC_ALU) return alu;
        if (src == SRC_PC4) return npc;
        if (w == WIDTH_BYTE) begin
            v = (word >> (32'd8 * off)) % 32'd256;
            if (s && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (w == WIDTH_HALF) begin
            v = (word >> (32'd16 * (off / 32'd2))) % 32'd65536;
            if (s && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    initial begin : main
        vec_t        vecs[9];
        int          rises;
        logic        prev;
        int          kind;
        int          lat;
        int          hold;
        int          stalls;
        rf_wr_src_e  src;
        mem_width_e  w;
        logic        s;
        logic [31:0] alu;
        logic [31:0] npc;
        logic [31:0] word;
        logic [31:0] exp;
        logic [4:0]  rd;

        vecs[0] = '{SRC_MEM, WIDTH_BYTE, 1'b1, 32'h0000_1001, 32'h0, 32'h0000_80FF, 32'hFFFF_FF80};
        vecs[1] = '{SRC_MEM, WIDTH_BYTE, 1'b0, 32'h0000_0003, 32'h0, 32'hA500_0000, 32'h0000_00A5};
        vecs[2] = '{SRC_MEM, WIDTH_BYTE, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_007F, 32'h0000_007F};
        vecs[3] = '{SRC_MEM, WIDTH_HALF, 1'b1, 32'h0000_0020, 32'h0, 32'h1234_8001, 32'hFFFF_8001};
        vecs[4] = '{SRC_MEM, WIDTH_HALF, 1'b0, 32'h0000_0002, 32'h0, 32'hBEEF_1234, 32'h0000_BEEF};
        vecs[5] = '{SRC_MEM, WIDTH_HALF, 1'b1, 32'h0000_0006, 32'h0, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[6] = '{SRC_MEM, WIDTH_WORD, 1'b1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{SRC_ALU, WIDTH_WORD, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[8] = '{SRC_PC4, WIDTH_BYTE, 1'b1, 32'h0000_0007, 32'h0000_0104, 32'h0, 32'h0000_0104};

        // Reset: stall request suppressed even with a live load and no response
        rst    = 1'b1;
        ctrl   = '0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        set_op(1'b1, SRC_MEM, WIDTH_WORD, 1'b0, 32'h0, 32'h0, 5'd3);
        #1;
        chk("rst_stall_req", stall_req, 32'd0);
        tick();
        chk("rst_valid_o", valid_o, 32'd0);
        chk("rst_rd_data", mem_state.rd_data, 32'd0);
        chk("rst_rf_wr_en", mem_state.rf_wr_en, 32'd0);
        chk("rst_meta", meta_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_op(1'b1, vecs[i].src, vecs[i].width, vecs[i].sign, vecs[i].alu, vecs[i].npc, 5'(i + 1));
            rdata  = vecs[i].word;
            rvalid = (vecs[i].src == SRC_MEM);
            #1;
            chk("vec_stall_req", stall_req, 32'd0);
            chk("vec_fwd_data", fwd.rd_data, vecs[i].exp);
            chk("vec_fwd_mem_read", fwd.mem_read, 32'd0);
            tick();
            chk("vec_rd_data", mem_state.rd_data, vecs[i].exp);
            chk("vec_valid_o", valid_o, 32'd1);
            chk("vec_rd", meta_o.rd, 32'(i + 1));
        end

        // JAL then ADD back to back
        set_op(1'b1, SRC_PC4, WIDTH_WORD, 1'b0, 32'h0000_0040, 32'h0000_0104, 5'd1);
        rvalid = 1'b0;
        #1;
        chk("jal_stall_req", stall_req, 32'd0);
        tick();
        chk("jal_rd_data", mem_state.rd_data, 32'h0000_0104);
        set_op(1'b1, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0000_0007, 32'h0000_0108, 5'd2);
        #1;
        chk("add_stall_req", stall_req, 32'd0);
        tick();
        chk("add_rd_data", mem_state.rd_data, 32'h0000_0007);
        chk("add_valid_o", valid_o, 32'd1);

        // LHU with two cycles of memory latency
        set_op(1'b1, SRC_MEM, WIDTH_HALF, 1'b0, 32'h0000_0202, 32'h0, 5'd9);
        rvalid = 1'b0;
        rdata  = 32'h0BAD_0BAD;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lhu_stall_req", stall_req, 32'd1);
            chk("lhu_fwd_valid", fwd.valid, 32'd0);
            tick();
            chk("lhu_bubble", valid_o, 32'd0);
        end
        rvalid = 1'b1;
        rdata  = 32'hBEEF_1234;
        #1;
        chk("lhu_stall_drop", stall_req, 32'd0);
        tick();
        chk("lhu_rd_data", mem_state.rd_data, 32'h0000_BEEF);
        chk("lhu_valid_o", valid_o, 32'd1);

        // Response arrives under an external stall held for three cycles
        set_op(1'b0, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
        rvalid = 1'b0;
        tick();
        prev  = valid_o;
        rises = 0;
        set_op(1'b1, SRC_MEM, WIDTH_WORD, 1'b0, 32'h0000_0040, 32'h0, 5'd12);
        ctrl.stall = 1'b1;
        rvalid     = 1'b1;
        rdata      = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_stall_req", stall_req, 32'd0);
            tick();
            if (valid_o && !prev) rises++;
            prev   = valid_o;
            rvalid = 1'b0;
            rdata  = 32'h1111_1111;
        end
        ctrl.stall = 1'b0;
        #1;
        chk("hold_fwd_data", fwd.rd_data, 32'hCAFE_F00D);
        tick();
        if (valid_o && !prev) rises++;
        prev = valid_o;
        chk("hold_rd_data", mem_state.rd_data, 32'hCAFE_F00D);
        set_op(1'b0, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        if (valid_o && !prev) rises++;
        chk("hold_valid_rises", rises, 32'd1);

        // Squash while waiting: drain the late response
        set_op(1'b1, SRC_MEM, WIDTH_WORD, 1'b0, 32'h0000_0080, 32'h0, 5'd4);
        #1;
        chk("sq_stall_req0", stall_req, 32'd1);
        tick();
        ctrl.squash = 1'b1;
        #1;
        chk("sq_stall_req1", stall_req, 32'd1);
        tick();
        chk("sq_valid_o", valid_o, 32'd0);
        ctrl.squash = 1'b0;
        set_op(1'b0, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drain_stall_req", stall_req, 32'd1);
            tick();
            chk("drain_valid_o", valid_o, 32'd0);
        end
        rvalid = 1'b1;
        rdata  = 32'h5555_5555;
        #1;
        chk("drain_stall_drop", stall_req, 32'd0);
        tick();
        chk("drain_discard_valid", valid_o, 32'd0);
        rvalid = 1'b0;
        set_op(1'b1, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0000_0099, 32'h0, 5'd5);
        #1;
        chk("post_drain_stall", stall_req, 32'd0);
        tick();
        chk("post_drain_rd", mem_state.rd_data, 32'h0000_0099);

        // Reset while waiting, then a stray response
        set_op(1'b1, SRC_MEM, WIDTH_WORD, 1'b0, 32'h0000_0010, 32'h0, 5'd6);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_stall_req", stall_req, 32'd0);
        tick();
        rst = 1'b0;
        chk("rst_wait_valid_o", valid_o, 32'd0);
        chk("rst_wait_rd_data", mem_state.rd_data, 32'd0);
        chk("rst_wait_meta", meta_o, 32'd0);
        set_op(1'b0, SRC_ALU, WIDTH_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
        rvalid = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        #1;
        chk("stray_stall_req", stall_req, 32'd0);
        tick();
        chk("stray_valid_o", valid_o, 32'd0);
        chk("stray_rd_data", mem_state.rd_data, 32'd0);
        rvalid = 1'b0;

        // Randomized transactions against the reference model
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 3);
            src  = (kind == 0) ? SRC_ALU : ((kind == 1) ? SRC_PC4 : SRC_MEM);
            lat  = (kind >= 2) ? $urandom_range(0, 3) : 0;
            hold = (kind >= 2) ? $urandom_range(0, 2) : 0;
            w    = mem_width_e'(2'($urandom_range(0, 2)));
            s    = 1'($urandom_range(0, 1));
            alu  = $urandom;
            npc  = $urandom;
            word = $urandom;
            rd   = 5'($urandom_range(0, 31));
            exp  = ref_value(src, w, s, alu, npc, word);
            set_op(1'b1, src, w, s, alu, npc, rd);
            ctrl   = '0;
            stalls = 0;
            for (int k = 0; k < lat; k++) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                #1;
                if (stall_req) stalls++;
                tick();
                chk("rand_bubble", valid_o, 32'd0);
            end
            rvalid = (src == SRC_MEM) ? 1'b1 : 1'($urandom_range(0, 1));
            rdata  = word;
            if (hold > 0) begin
                ctrl.stall = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    #1;
                    chk("rand_hold_stall_req", stall_req, 32'd0);
                    prev = valid_o;
                    tick();
                    chk("rand_hold_valid", valid_o, 32'(prev));
                    rvalid = 1'b0;
                    rdata  = $urandom;
                end
                ctrl.stall = 1'b0;
            end
            #1;
            if (stall_req) stalls++;
            chk("rand_stall_cycles", stalls, 32'(lat));
            chk("rand_fwd_valid", fwd.valid, 32'd1);
            chk("rand_fwd_data", fwd.rd_data, exp);
            tick();
            chk("rand_rd_data", mem_state.rd_data, exp);
            chk("rand_valid_o", valid_o, 32'd1);
            chk("rand_rd", meta_o.rd, 32'(rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
